// File: rtl/seg7_pkg.sv
// Segment-bus constants shared by the 7-segment encoder and the scan capture.
// Code patterns are active-high {a,b,c,d,e,f,g}, MSB = a.
package seg7_pkg;
  localparam int SEG_A  = 7;
  localparam int SEG_B  = 6;
  localparam int SEG_C  = 5;
  localparam int SEG_D  = 4;
  localparam int SEG_E  = 3;
  localparam int SEG_F  = 2;
  localparam int SEG_G  = 1;
  localparam int SEG_DP = 0;

  localparam logic [6:0] SEG_CODES [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  // Older drivers light segments a,b,c,f,g without e for 'A'
  localparam logic [6:0] SEG_ALIAS_A = 7'b1110011;
  localparam logic [6:0] SEG_BLANK   = 7'b0000000;

  typedef enum logic [1:0] {ST_IDLE, ST_SETTLE, ST_HOLD} scan_st_e;
endpackage

// File: rtl/seg7_scan_capture_if.sv
// Display bus (seg_n/an_n) plus the captured register image and status.
interface seg7_scan_capture_if #(parameter int NDIG = 8);
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;

  logic [7:0]        seg_n;
  logic [NDIG-1:0]   an_n;
  logic [4*NDIG-1:0] digits;
  logic [NDIG-1:0]   dp;
  logic [NDIG-1:0]   dig_valid;
  logic [NDIG-1:0]   dig_err;
  logic [NDIG-1:0]   dig_blank;
  logic              upd_valid;
  logic [IW-1:0]     upd_idx;
  logic              frame_done;

  modport master (
    output seg_n, an_n,
    input  digits, dp, dig_valid, dig_err, dig_blank, upd_valid, upd_idx, frame_done
  );
  modport slave (
    input  seg_n, an_n,
    output digits, dp, dig_valid, dig_err, dig_blank, upd_valid, upd_idx, frame_done
  );
endinterface

// File: rtl/seg7_decode.sv
// Active-high segment pattern back to hex; blank and undecodable flagged.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [6:0] pat,
  output logic       hit,
  output logic       blank,
  output logic [3:0] val
);
  always_comb begin
    hit   = 1'b0;
    val   = 4'h0;
    blank = (pat == SEG_BLANK);
    for (int k = 0; k < 16; k++) begin
      if (pat == SEG_CODES[k]) begin
        hit = 1'b1;
        val = k[3:0];
      end
    end
    if (pat == SEG_ALIAS_A) begin
      hit = 1'b1;
      val = 4'hA;
    end
  end
endmodule

// File: rtl/seg7_scan_capture.sv
// Watches a multiplexed active-low 7-seg bus, commits each digit once its
// sample has been seen STABLE times, and keeps a per-digit register image.
module seg7_scan_capture
  import seg7_pkg::*;
#(
  parameter int NDIG   = 8,
  parameter int STABLE = 4
) (
  input logic               clk,
  input logic               rst,
  seg7_scan_capture_if.slave bus
);
  localparam int IW = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam int CW = $clog2(STABLE + 1);
  localparam int SW = 8 + NDIG;

  logic [SW-1:0]     samp, s_q;
  logic              valid, same, commit;
  scan_st_e          st;
  logic [CW-1:0]     cnt;
  logic [IW-1:0]     s_idx;
  logic [6:0]        pat;
  logic              hit, blank;
  logic [3:0]        val;
  logic [NDIG-1:0]   seen_q, seen_nxt;

  logic [4*NDIG-1:0] digits_q;
  logic [NDIG-1:0]   dp_q, vld_q, err_q, blk_q;
  logic              upd_q, frame_q;
  logic [IW-1:0]     idx_q;

  assign samp  = {bus.seg_n, bus.an_n};
  assign valid = $onehot(~bus.an_n);
  assign same  = (samp == s_q);

  // s_q is always a valid selection while in SETTLE, so commit decodes it
  assign commit = (st == ST_SETTLE) && (cnt == CW'(STABLE));
  assign pat    = ~s_q[SW-1:NDIG+1];

  always_comb begin
    s_idx = '0;
    for (int i = 0; i < NDIG; i++)
      if (!s_q[i]) s_idx = IW'(i);
  end

  assign seen_nxt = seen_q | (NDIG'(1) << s_idx);

  seg7_decode u_dec (.pat(pat), .hit(hit), .blank(blank), .val(val));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s_q      <= '0;
      st       <= ST_IDLE;
      cnt      <= '0;
      seen_q   <= '0;
      digits_q <= '0;
      dp_q     <= '0;
      vld_q    <= '0;
      err_q    <= '0;
      blk_q    <= '0;
      upd_q    <= 1'b0;
      frame_q  <= 1'b0;
      idx_q    <= '0;
    end else begin
      s_q     <= samp;
      upd_q   <= commit;
      frame_q <= 1'b0;

      if (commit) begin
        idx_q        <= s_idx;
        vld_q[s_idx] <= 1'b1;
        dp_q[s_idx]  <= ~s_q[NDIG];
        err_q[s_idx] <= ~hit & ~blank;
        blk_q[s_idx] <= blank;
        if (hit) digits_q[4*int'(s_idx) +: 4] <= val;
        // the completing commit starts the next frame from an empty mask
        if (&seen_nxt) begin
          frame_q <= 1'b1;
          seen_q  <= '0;
        end else begin
          seen_q  <= seen_nxt;
        end
      end

      case (st)
        ST_IDLE: begin
          if (valid) begin
            st  <= ST_SETTLE;
            cnt <= CW'(1);
          end else begin
            cnt <= '0;
          end
        end
        default: begin
          if (!valid) begin
            st  <= ST_IDLE;
            cnt <= '0;
          end else if (!same) begin
            st  <= ST_SETTLE;
            cnt <= CW'(1);
          end else if (st == ST_SETTLE) begin
            if (commit) st  <= ST_HOLD;
            else        cnt <= cnt + CW'(1);
          end
        end
      endcase
    end
  end

  assign bus.digits     = digits_q;
  assign bus.dp         = dp_q;
  assign bus.dig_valid  = vld_q;
  assign bus.dig_err    = err_q;
  assign bus.dig_blank  = blk_q;
  assign bus.upd_valid  = upd_q;
  assign bus.upd_idx    = idx_q;
  assign bus.frame_done = frame_q;
endmodule

// File: tb/tb_seg7_scan_capture.sv
// Directed bench for seg7_scan_capture with a run-length reference model.
module tb_seg7_scan_capture;
  localparam int NDIG   = 8;
  localparam int STABLE = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  seg7_scan_capture_if #(.NDIG(NDIG)) bus();
  seg7_scan_capture #(.NDIG(NDIG), .STABLE(STABLE)) dut (.clk(clk), .rst(rst), .bus(bus));

  int errors = 0, checks = 0;
  int upd_cnt = 0, frame_cnt = 0, frame7_cnt = 0;

  logic [6:0] tbl [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  // reference model state
  logic [7:0]      m_seg = '0;
  logic [NDIG-1:0] m_an = '0;
  int              run = 0;
  bit              pend = 0;
  logic [7:0]      pend_seg = '0;
  int              pend_idx = 0;
  logic [3:0]      e_dig [NDIG];
  logic [NDIG-1:0] e_dp = '0, e_val = '0, e_err = '0, e_blank = '0, seen = '0;
  bit              e_upd = 0, e_frame = 0;
  int              e_idx = 0;

  task automatic cmp(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int sel_idx(input logic [NDIG-1:0] a);
    int n = 0;
    int idx = -1;
    for (int i = 0; i < NDIG; i++) if (!a[i]) begin n++; idx = i; end
    return (n == 1) ? idx : -1;
  endfunction

  task automatic m_reset();
    m_seg = '0; m_an = '0; run = 0; pend = 0;
    e_dp = '0; e_val = '0; e_err = '0; e_blank = '0; seen = '0;
    e_upd = 0; e_frame = 0; e_idx = 0;
    for (int i = 0; i < NDIG; i++) e_dig[i] = '0;
  endtask

  // model: a commit shows up one edge after STABLE identical valid samples
  initial begin
    logic [6:0] p;
    bit found, same;
    int v, old, si;
    m_reset();
    forever begin
      @(posedge clk or posedge rst);
      if (rst) m_reset();
      else begin
        e_upd = 0; e_frame = 0;
        if (pend) begin
          p = ~pend_seg[7:1];
          found = 0; v = 0;
          for (int k = 0; k < 16; k++) if (p == tbl[k]) begin found = 1; v = k; end
          if (p == 7'b1110011) begin found = 1; v = 10; end
          e_upd = 1; e_idx = pend_idx;
          e_val[pend_idx] = 1'b1;
          e_dp[pend_idx]  = ~pend_seg[0];
          if (p == 7'b0) begin
            e_blank[pend_idx] = 1'b1; e_err[pend_idx] = 1'b0;
          end else if (found) begin
            e_dig[pend_idx] = 4'(v); e_blank[pend_idx] = 1'b0; e_err[pend_idx] = 1'b0;
          end else begin
            e_blank[pend_idx] = 1'b0; e_err[pend_idx] = 1'b1;
          end
          seen[pend_idx] = 1'b1;
          if (&seen) begin e_frame = 1; seen = '0; end
        end
        si   = sel_idx(bus.an_n);
        same = ({bus.seg_n, bus.an_n} == {m_seg, m_an});
        old  = run;
        if (si < 0)      run = 0;
        else if (!same)  run = 1;
        else if (run < STABLE) run++;
        pend = (si >= 0) && (run == STABLE) && (old != STABLE || !same);
        pend_seg = bus.seg_n; pend_idx = si;
        m_seg = bus.seg_n; m_an = bus.an_n;
      end
    end
  end

  // compare every cycle on the falling edge
  initial begin
    logic [4*NDIG-1:0] ed;
    forever begin
      @(negedge clk);
      for (int i = 0; i < NDIG; i++) ed[4*i +: 4] = e_dig[i];
      cmp("digits", bus.digits, ed);
      cmp("dp", bus.dp, e_dp);
      cmp("dig_valid", bus.dig_valid, e_val);
      cmp("dig_err", bus.dig_err, e_err);
      cmp("dig_blank", bus.dig_blank, e_blank);
      cmp("upd_valid", bus.upd_valid, e_upd);
      cmp("frame_done", bus.frame_done, e_frame);
      if (e_upd) cmp("upd_idx", bus.upd_idx, e_idx);
      if (bus.upd_valid) upd_cnt++;
      if (bus.frame_done) frame_cnt++;
      if (bus.frame_done && bus.upd_valid && bus.upd_idx == 3'd7) frame7_cnt++;
    end
  end

  task automatic hold(input logic [7:0] s, input logic [NDIG-1:0] a, input int n);
    bus.seg_n = s; bus.an_n = a;
    repeat (n) @(posedge clk);
    #2;
  endtask

  initial begin
    int b0, b1, b2;
    logic [NDIG-1:0] a;
    bus.seg_n = 8'hFF; bus.an_n = '1; rst = 1'b1;
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // idle after reset
    hold(8'hFF, '1, 20);
    cmp("idle_upd_cnt", upd_cnt, 0);
    cmp("idle_digits", bus.digits, 0);
    cmp("idle_valid", bus.dig_valid, 0);

    // single commit latency: digit 2 showing '3'
    b0 = upd_cnt;
    hold(8'b00001101, ~8'h04, 4);
    cmp("lat_early", bus.upd_valid, 0);
    hold(8'b00001101, ~8'h04, 1);
    cmp("lat_upd", bus.upd_valid, 1);
    cmp("lat_idx", bus.upd_idx, 2);
    cmp("lat_dig", bus.digits[11:8], 3);
    cmp("lat_dp", bus.dp[2], 0);
    hold(8'b00001101, ~8'h04, 1);
    cmp("lat_pulse1", bus.upd_valid, 0);
    hold(8'b00001101, ~8'h04, 50);
    cmp("lat_once", upd_cnt - b0, 1);

    // glitch: '5' for 3 samples, then '8' with dp lit
    b0 = upd_cnt;
    hold(8'b01001001, ~8'h02, 3);
    hold(8'b00000000, ~8'h02, 6);
    cmp("glitch_cnt", upd_cnt - b0, 1);
    cmp("glitch_dig", bus.digits[7:4], 8);
    cmp("glitch_dp", bus.dp[1], 1);

    // full frame from a clean reset
    rst = 1'b1; @(posedge clk); #2 rst = 1'b0;
    b0 = upd_cnt; b1 = frame_cnt; b2 = frame7_cnt;
    for (int d = 0; d < NDIG; d++) begin
      a = ~(NDIG'(1) << d);
      hold({~tbl[d], 1'b1}, a, 6);
      hold(8'hFF, '1, 2);
    end
    cmp("frame_upds", upd_cnt - b0, 8);
    cmp("frame_done_cnt", frame_cnt - b1, 1);
    cmp("frame_on_d7", frame7_cnt - b2, 1);
    cmp("frame_digits", bus.digits, 32'h76543210);

    // error, blank, legacy alias on digit 0
    hold(8'b00110111, ~8'h01, 6);
    cmp("err_flag", bus.dig_err[0], 1);
    cmp("err_blank", bus.dig_blank[0], 0);
    cmp("err_dig", bus.digits[3:0], 0);
    hold(8'hFF, ~8'h01, 6);
    cmp("blank_flag", bus.dig_blank[0], 1);
    cmp("blank_err", bus.dig_err[0], 0);
    cmp("blank_dig", bus.digits[3:0], 0);
    hold(8'b00011001, ~8'h01, 6);
    cmp("alias_dig", bus.digits[3:0], 4'hA);
    cmp("alias_err", bus.dig_err[0], 0);
    cmp("alias_blank", bus.dig_blank[0], 0);
    b0 = upd_cnt;
    hold(8'hFF, '1, 2);
    hold(8'b00011001, ~8'h01, 6);
    cmp("reselect", upd_cnt - b0, 1);

    // ghosting never commits
    b0 = upd_cnt;
    hold(8'b00001001, ~8'h03, 10);
    cmp("ghost", upd_cnt - b0, 0);

    // reset at cnt=2 discards the pending digit
    hold(8'b00001001, ~8'h08, 2);
    rst = 1'b1;
    #1;
    cmp("rst_digits", bus.digits, 0);
    cmp("rst_valid", bus.dig_valid, 0);
    cmp("rst_upd", bus.upd_valid, 0);
    @(posedge clk); #2 rst = 1'b0;
    b0 = upd_cnt;
    repeat (4) @(posedge clk);
    #2;
    cmp("rst_no_early", upd_cnt - b0, 0);
    cmp("rst_no_upd", bus.upd_valid, 0);
    @(posedge clk); #2;
    cmp("rst_fresh_upd", bus.upd_valid, 1);
    cmp("rst_fresh_idx", bus.upd_idx, 3);
    cmp("rst_fresh_dig", bus.digits[15:12], 9);

    hold(8'hFF, '1, 5);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
